// File: rtl/hyper_evt_tracker.sv
// Per-channel HyperBus EOT classifier: an in-order tag FIFO records the direction of each
// launched transfer so every end-of-transfer pulse is reported as a read or a write event.
module hyper_evt_tracker #(
    parameter int NB_CH = 2,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   sys_clk_i,
    input  logic                   rstn_i,
    input  logic [NB_CH-1:0]       rx_start_i,
    input  logic [NB_CH-1:0]       tx_start_i,
    input  logic [NB_CH-1:0]       eot_i,
    input  logic [NB_CH-1:0]       clr_i,
    output logic [NB_CH-1:0]       evt_rd_eot_o,
    output logic [NB_CH-1:0]       evt_wr_eot_o,
    output logic [NB_CH*CNT_W-1:0] pending_o,
    output logic [NB_CH-1:0]       ovf_o,
    output logic [NB_CH-1:0]       udf_o,
    output logic [NB_CH-1:0]       err_o
);

    localparam int PTR_W = $clog2(DEPTH);

    for (genvar c = 0; c < NB_CH; c++) begin : g_ch
        logic [DEPTH-1:0] fifo_q;
        logic [PTR_W-1:0] wptr_q, wptr_d;
        logic [PTR_W-1:0] rptr_q, rptr_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             last_q;
        logic             rd_q, wr_q;
        logic             ovf_q, udf_q, err_q;

        logic push_req, empty, full, pop, bypass, do_push, drop, cls_tag, udf_set;

        always_comb begin
            push_req = rx_start_i[c] ^ tx_start_i[c];
            empty    = (cnt_q == '0);
            full     = (cnt_q == CNT_W'(DEPTH));
            pop      = eot_i[c] & ~empty;
            // An EOT on an empty channel is satisfied directly by a launch in the same cycle.
            bypass   = eot_i[c] & empty & push_req;
            do_push  = push_req & ~bypass & (~full | pop);
            drop     = push_req & full & ~pop;
            udf_set  = eot_i[c] & empty & ~push_req;
            if (!empty) begin
                cls_tag = fifo_q[rptr_q];
            end else if (push_req) begin
                cls_tag = rx_start_i[c];
            end else begin
                cls_tag = last_q;
            end

            wptr_d = do_push ? wptr_q + PTR_W'(1) : wptr_q;
            rptr_d = pop ? rptr_q + PTR_W'(1) : rptr_q;
            if (do_push && !pop) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (pop && !do_push) begin
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end

        always_ff @(posedge sys_clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                fifo_q <= '0;
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
                last_q <= 1'b0;
                rd_q   <= 1'b0;
                wr_q   <= 1'b0;
                ovf_q  <= 1'b0;
                udf_q  <= 1'b0;
                err_q  <= 1'b0;
            end else if (clr_i[c]) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
                last_q <= 1'b0;
                rd_q   <= 1'b0;
                wr_q   <= 1'b0;
                ovf_q  <= 1'b0;
                udf_q  <= 1'b0;
                err_q  <= 1'b0;
            end else begin
                if (do_push) begin
                    fifo_q[wptr_q] <= rx_start_i[c];
                end
                wptr_q <= wptr_d;
                rptr_q <= rptr_d;
                cnt_q  <= cnt_d;
                if (eot_i[c]) begin
                    last_q <= cls_tag;
                end
                rd_q   <= eot_i[c] & cls_tag;
                wr_q   <= eot_i[c] & ~cls_tag;
                ovf_q  <= ovf_q | drop;
                udf_q  <= udf_q | udf_set;
                err_q  <= err_q | (rx_start_i[c] & tx_start_i[c]);
            end
        end

        assign evt_rd_eot_o[c]              = rd_q;
        assign evt_wr_eot_o[c]              = wr_q;
        assign pending_o[c*CNT_W +: CNT_W]  = cnt_q;
        assign ovf_o[c]                     = ovf_q;
        assign udf_o[c]                     = udf_q;
        assign err_o[c]                     = err_q;
    end

endmodule
